// File: rtl/jtag_probe_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtag_probe_master: host-side JTAG initiator, DR/IR scans, TAP reset,     |
// | idle clocks over a valid/ready command port.         Revision: 1.0       |
// +--------------------------------------------------------------------------+
module jtag_probe_master #(
    parameter int W   = 32,
    parameter int DIV = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [$clog2(W):0]        cmd_len,
    input  logic [W-1:0]              cmd_tdi,
    output logic                      rsp_valid,
    output logic [W-1:0]              rsp_tdo,
    output logic                      tck,
    output logic                      tms,
    output logic                      tdi,
    input  logic                      tdo
);
    localparam int LEN_W = $clog2(W) + 1;
    localparam int IDX_W = $clog2(W);
    localparam int DCW   = $clog2(DIV);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state;
    logic             ctl_op;     // op 2/3: prefix sequence only, no shift
    logic [LEN_W-1:0] len_q;
    logic [W-1:0]     tdi_q;
    logic [LEN_W-1:0] cnt;
    logic [5:0]       pre_sr;
    logic [DCW-1:0]   dcnt;

    logic             xfer;
    logic             degen;
    logic             half_end;
    logic             tck_end;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;

    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_DONE);
    assign xfer      = cmd_valid & cmd_ready;
    assign half_end  = (dcnt == DCW'(DIV - 1));
    assign tck_end   = tck & half_end;
    assign idx       = cnt[IDX_W-1:0];
    assign idx_nxt   = idx + IDX_W'(1);

    // Commands that would clock nothing complete immediately.
    assign degen = cmd_op[1] ? ((cmd_op[0] == 1'b1) && (cmd_len == '0))
                             : ((cmd_len == '0) || (cmd_len > LEN_W'(W)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ctl_op  <= 1'b0;
            len_q   <= '0;
            tdi_q   <= '0;
            cnt     <= '0;
            pre_sr  <= '0;
            dcnt    <= '0;
            tck     <= 1'b0;
            tms     <= 1'b1;
            tdi     <= 1'b0;
            rsp_tdo <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        ctl_op  <= cmd_op[1];
                        len_q   <= cmd_len;
                        tdi_q   <= cmd_tdi;
                        rsp_tdo <= '0;
                        dcnt    <= '0;
                        tck     <= 1'b0;
                        tdi     <= 1'b0;
                        if (degen) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_PRE;
                            // pre_sr holds the prefix TMS bits, LSB first
                            case (cmd_op)
                                2'd0: begin cnt <= LEN_W'(3); pre_sr <= 6'b000001; tms <= 1'b1; end
                                2'd1: begin cnt <= LEN_W'(4); pre_sr <= 6'b000011; tms <= 1'b1; end
                                2'd2: begin cnt <= LEN_W'(6); pre_sr <= 6'b011111; tms <= 1'b1; end
                                default: begin cnt <= cmd_len; pre_sr <= 6'b000000; tms <= 1'b0; end
                            endcase
                        end
                    end
                end
                S_PRE, S_SHIFT, S_POST: begin
                    if (half_end) begin
                        dcnt <= '0;
                        tck  <= ~tck;
                    end else begin
                        dcnt <= dcnt + DCW'(1);
                    end
                    if (tck_end) begin
                        case (state)
                            S_PRE: begin
                                if (cnt == LEN_W'(1)) begin
                                    if (ctl_op) begin
                                        state <= S_DONE;
                                    end else begin
                                        state <= S_SHIFT;
                                        cnt   <= '0;
                                        tms   <= (len_q == LEN_W'(1));
                                        tdi   <= tdi_q[0];
                                    end
                                end else begin
                                    cnt    <= cnt - LEN_W'(1);
                                    pre_sr <= pre_sr >> 1;
                                    tms    <= pre_sr[1];
                                end
                            end
                            S_SHIFT: begin
                                rsp_tdo[idx] <= tdo;
                                if (cnt == len_q - LEN_W'(1)) begin
                                    state <= S_POST;
                                    cnt   <= '0;
                                    tms   <= 1'b1;
                                    tdi   <= 1'b0;
                                end else begin
                                    cnt <= cnt + LEN_W'(1);
                                    tms <= (cnt + LEN_W'(2) == len_q);
                                    tdi <= tdi_q[idx_nxt];
                                end
                            end
                            default: begin
                                if (cnt == '0) begin
                                    cnt <= LEN_W'(1);
                                    tms <= 1'b0;
                                end else begin
                                    state <= S_DONE;
                                end
                            end
                        endcase
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_jtag_probe_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_jtag_probe_master: directed bench with a behavioural TAP model.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_jtag_probe_master;
    localparam int W     = 32;
    localparam int DIV   = 2;
    localparam int LEN_W = $clog2(W) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic [W-1:0]     cmd_tdi;
    logic             rsp_valid;
    logic [W-1:0]     rsp_tdo;
    logic             tck, tms, tdi;
    logic             tdo = 1'b0;

    jtag_probe_master #(.W(W), .DIV(DIV)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_tdi(cmd_tdi),
        .rsp_valid(rsp_valid), .rsp_tdo(rsp_tdo),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observation history, indexed by a monotonic tck count
    int   cyc = 0;
    int   tck_total = 0;
    int   rsp_total = 0;
    logic tms_h [4096];
    logic tdi_h [4096];
    int   rise_h[4096];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rsp_valid) rsp_total++;
    always @(posedge tck) begin
        if (tck_total < 4096) begin
            tms_h[tck_total]  = tms;
            tdi_h[tck_total]  = tdi;
            rise_h[tck_total] = cyc;
        end
        tck_total++;
    end

    // Behavioural TAP: 5-bit IR, IDCODE=1 (0xDEADBEEF), BYPASS=0x1F
    localparam logic [3:0] TLR = 4'd0,  RTI = 4'd1,  SELDR = 4'd2, CAPDR = 4'd3,
                           SHDR = 4'd4, EX1DR = 4'd5, PSDR = 4'd6, EX2DR = 4'd7,
                           UPDR = 4'd8, SELIR = 4'd9, CAPIR = 4'd10, SHIR = 4'd11,
                           EX1IR = 4'd12, PSIR = 4'd13, EX2IR = 4'd14, UPIR = 4'd15;
    logic [3:0]  ts = TLR;
    logic [4:0]  ir = 5'h01;
    logic [4:0]  ir_sr = 5'h00;
    logic [31:0] dr_sr = 32'h0;
    logic        bp = 1'b0;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PSDR;
            PSDR:  return m ? EX2DR : PSDR;
            EX2DR: return m ? UPDR  : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PSIR;
            PSIR:  return m ? EX2IR : PSIR;
            EX2IR: return m ? UPIR  : SHIR;
            default: return m ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        case (ts)
            TLR:   ir <= 5'h01;
            CAPDR: if (ir == 5'h1F) bp <= 1'b0; else dr_sr <= 32'hDEADBEEF;
            SHDR:  if (ir == 5'h1F) bp <= tdi;  else dr_sr <= {tdi, dr_sr[31:1]};
            CAPIR: ir_sr <= 5'h01;
            SHIR:  ir_sr <= {tdi, ir_sr[4:1]};
            UPIR:  ir <= ir_sr;
            default: ;
        endcase
        ts <= tap_next(ts, tms);
    end

    always @(negedge tck) begin
        if (ts == SHDR)      tdo <= (ir == 5'h1F) ? bp : dr_sr[0];
        else if (ts == SHIR) tdo <= ir_sr[0];
    end

    function automatic logic [63:0] tms_vec(input int b, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = tms_h[b + i];
        return v;
    endfunction

    function automatic logic [63:0] tdi_vec(input int b, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = tdi_h[b + i];
        return v;
    endfunction

    // Issue one command from a negedge and return at the negedge where rsp_valid is seen
    task automatic run_cmd(input logic [1:0] op, input int len, input logic [W-1:0] data,
                           output logic [W-1:0] r, output int lat, output int ntck, output int base);
        int n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        check("cmd_ready_before_cmd", 64'(cmd_ready), 64'd1);
        base      = tck_total;
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        cmd_tdi   = data;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 2000) begin @(negedge clk); lat++; end
        check("rsp_valid_seen", 64'(rsp_valid), 64'd1);
        r    = rsp_tdo;
        ntck = tck_total - base;
    endtask

    logic [W-1:0] r;
    int lat, ntck, base, r0;
    int acc_cyc[3], rsp_cyc[3];
    int na, nr;
    logic any_tms, any_tdi;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_tdi = '0;
        repeat (3) @(negedge clk);
        check("rst_tck", 64'(tck), 64'd0);
        check("rst_tms", 64'(tms), 64'd1);
        check("rst_tdi", 64'(tdi), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_tdo", 64'(rsp_tdo), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // TAP reset
        run_cmd(2'd2, 0, '0, r, lat, ntck, base);
        check("op2_tcks", 64'(ntck), 64'd6);
        check("op2_tms", tms_vec(base, 6), 64'h1F);
        check("op2_period", 64'(rise_h[base+1] - rise_h[base]), 64'(2*DIV));
        check("op2_done_tck_low", 64'(tck), 64'd0);
        @(negedge clk);
        check("op2_rsp_one_clk", 64'(rsp_valid), 64'd0);
        check("op2_ready_back", 64'(cmd_ready), 64'd1);

        // IR <- BYPASS, then 8-bit DR through bypass
        run_cmd(2'd1, 5, 32'h1F, r, lat, ntck, base);
        check("ir_tcks", 64'(ntck), 64'd11);
        check("ir_tms", tms_vec(base, 11), 64'h303);
        check("ir_capture", 64'(r), 64'h01);
        run_cmd(2'd0, 8, 32'hA5, r, lat, ntck, base);
        check("byp_tcks", 64'(ntck), 64'd13);
        check("byp_tms", tms_vec(base, 13), 64'hC01);
        check("byp_tdi_bits", tdi_vec(base + 3, 8), 64'hA5);
        check("byp_rsp", 64'(r), 64'h4A);

        // IDCODE read
        run_cmd(2'd2, 0, '0, r, lat, ntck, base);
        run_cmd(2'd1, 5, 32'h01, r, lat, ntck, base);
        check("idc_ir_tcks", 64'(ntck), 64'd11);
        run_cmd(2'd0, 32, 32'h0, r, lat, ntck, base);
        check("idc_tcks", 64'(ntck), 64'd37);
        check("idc_rsp", 64'(r), 64'hDEADBEEF);

        // Degenerate lengths
        run_cmd(2'd0, 0, '1, r, lat, ntck, base);
        check("len0_lat", 64'(lat), 64'd1);
        check("len0_tcks", 64'(ntck), 64'd0);
        check("len0_rsp", 64'(r), 64'd0);
        run_cmd(2'd0, W + 1, '1, r, lat, ntck, base);
        check("lenW1_lat", 64'(lat), 64'd1);
        check("lenW1_tcks", 64'(ntck), 64'd0);
        check("lenW1_rsp", 64'(r), 64'd0);
        run_cmd(2'd3, 0, '0, r, lat, ntck, base);
        check("idle0_lat", 64'(lat), 64'd1);
        check("idle0_tcks", 64'(ntck), 64'd0);
        @(negedge clk);

        // Reset in the middle of a 32-bit shift
        r0 = rsp_total;
        cmd_op = 2'd0; cmd_len = LEN_W'(32); cmd_tdi = '1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_in_shift_tdi", 64'(tdi), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_tck", 64'(tck), 64'd0);
        check("mid_rst_tms", 64'(tms), 64'd1);
        check("mid_rst_tdi", 64'(tdi), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("mid_no_rsp", 64'(rsp_total - r0), 64'd0);
        run_cmd(2'd2, 0, '0, r, lat, ntck, base);
        check("post_rst_op2_tcks", 64'(ntck), 64'd6);
        check("post_rst_op2_tms", tms_vec(base, 6), 64'h1F);
        run_cmd(2'd0, 32, 32'h0, r, lat, ntck, base);
        check("post_rst_idcode", 64'(r), 64'hDEADBEEF);
        @(negedge clk);

        // Back-to-back idle-clock commands with cmd_valid held
        base = tck_total;
        cmd_op = 2'd3; cmd_len = LEN_W'(4); cmd_tdi = '1; cmd_valid = 1'b1;
        na = 0; nr = 0;
        for (int c = 0; c < 300 && nr < 3; c++) begin
            if (cmd_valid && cmd_ready && na < 3) begin acc_cyc[na] = c; na++; end
            if (rsp_valid) begin
                rsp_cyc[nr] = c; nr++;
                if (nr == 3) cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_rsp_count", 64'(nr), 64'd3);
        check("b2b_acc_count", 64'(na), 64'd3);
        for (int k = 0; k < 3; k++)
            check("b2b_cmd_len", 64'(rsp_cyc[k] - acc_cyc[k]), 64'(4*2*DIV + 1));
        check("b2b_gap1", 64'(acc_cyc[1] - rsp_cyc[0]), 64'd1);
        check("b2b_gap2", 64'(acc_cyc[2] - rsp_cyc[1]), 64'd1);
        check("b2b_tcks", 64'(tck_total - base), 64'd12);
        any_tms = 1'b0; any_tdi = 1'b0;
        for (int i = 0; i < 12; i++) begin
            any_tms |= tms_h[base + i];
            any_tdi |= tdi_h[base + i];
        end
        check("b2b_tms_low", 64'(any_tms), 64'd0);
        check("b2b_tdi_low", 64'(any_tdi), 64'd0);
        repeat (3) @(negedge clk);
        check("b2b_no_fourth", 64'(cmd_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
